exp_request_arbiter: RTL and testbench

EXP_REQUEST_ARBITER -- requirements
Module: exp_request_arbiter

---
 rtl/exp_request_arbiter.sv | 144 ++++++++++++++
 tb/tb_exp_request_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exp_request_arbiter.sv
// Round-robin arbiter that shares one exp unit among NUM_REQ requesters.
// Operands are saturated into [-1.0, 0] (S1.23.40) before issue; one transaction in flight at a time.
module exp_request_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 255,
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [64*NUM_REQ-1:0]  req_data,
    output logic [NUM_REQ-1:0]     rsp_valid,
    input  logic [NUM_REQ-1:0]     rsp_ready,
    output logic [63:0]            rsp_data,
    output logic                   rsp_clamped,
    output logic                   rsp_timeout,
    output logic [63:0]            eu_x_in,
    output logic                   eu_x_in_valid,
    input  logic                   eu_x_in_ready,
    input  logic [63:0]            eu_exp_out,
    input  logic                   eu_output_valid,
    output logic                   eu_output_ready,
    output logic [GW-1:0]          grant_id,
    output logic                   busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DELIVER} state_t;

    localparam logic signed [63:0] NEG_ONE = 64'shFFFFFF0000000000;

    state_t              state_q, state_d;
    logic [GW-1:0]       grant_q, grant_d;
    logic [GW-1:0]       last_q, last_d;
    logic [63:0]         x_q, x_d;
    logic                clamp_q, clamp_d;
    logic [63:0]         data_q, data_d;
    logic                tmo_q, tmo_d;
    logic [15:0]         cnt_q, cnt_d;
    logic                found;
    logic [GW-1:0]       win;

    // Returns {clamp_flag, saturated_operand}; exp of a positive argument is never requested.
    function automatic logic [64:0] saturate(input logic signed [63:0] x);
        if (x > 64'sd0)
            return {1'b1, 64'd0};
        else if (x < NEG_ONE)
            return {1'b1, NEG_ONE};
        else
            return {1'b0, x};
    endfunction

    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!found && req_valid[(int'(last_q) + i) % NUM_REQ]) begin
                found = 1'b1;
                win   = GW'((int'(last_q) + i) % NUM_REQ);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        x_d       = x_q;
        clamp_d   = clamp_q;
        data_d    = data_q;
        tmo_d     = tmo_q;
        cnt_d     = cnt_q;
        req_ready = '0;
        rsp_valid = '0;
        case (state_q)
            IDLE: begin
                if (found && !rst) begin
                    req_ready[win]   = 1'b1;
                    grant_d          = win;
                    last_d           = win;
                    {clamp_d, x_d}   = saturate(req_data[64*int'(win) +: 64]);
                    state_d          = ISSUE;
                end
            end
            ISSUE: begin
                if (eu_x_in_ready) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (eu_output_valid) begin
                    data_d  = eu_exp_out;
                    tmo_d   = 1'b0;
                    state_d = DELIVER;
                end else if (int'(cnt_q) + 1 >= TIMEOUT) begin
                    data_d  = '0;
                    tmo_d   = 1'b1;
                    state_d = DELIVER;
                end else begin
                    cnt_d   = cnt_q + 16'd1;
                end
            end
            DELIVER: begin
                rsp_valid[grant_q] = 1'b1;
                if (rsp_ready[grant_q])
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= GW'(NUM_REQ - 1);
            x_q     <= '0;
            clamp_q <= 1'b0;
            data_q  <= '0;
            tmo_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            x_q     <= x_d;
            clamp_q <= clamp_d;
            data_q  <= data_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
        end
    end

    assign eu_x_in         = x_q;
    assign eu_x_in_valid   = (state_q == ISSUE);
    assign eu_output_ready = (state_q == WAIT);
    assign rsp_data        = data_q;
    assign rsp_clamped     = clamp_q;
    assign rsp_timeout     = tmo_q;
    assign grant_id        = grant_q;
    assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_exp_request_arbiter.sv
// Bench for exp_request_arbiter: exp-unit stub returning ~x after a programmable latency,
// plus a transaction-level model of grant order, saturation, latency and timeout.
module tb_exp_request_arbiter;

    localparam int N       = 4;
    localparam int TIMEOUT = 255;
    localparam logic [63:0] NEG1 = 64'hFFFFFF0000000000;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [64*N-1:0] req_data;
    logic [N-1:0]    rsp_valid;
    logic [N-1:0]    rsp_ready;
    logic [63:0]     rsp_data;
    logic            rsp_clamped;
    logic            rsp_timeout;
    logic [63:0]     eu_x_in;
    logic            eu_x_in_valid;
    logic            eu_x_in_ready;
    logic [63:0]     eu_exp_out;
    logic            eu_output_valid;
    logic            eu_output_ready;
    logic [1:0]      grant_id;
    logic            busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_grant;
    int mdl_grant;
    logic [63:0] last_exp;

    // exp-unit stub
    logic        stub_pend;
    int          stub_cnt;
    logic [63:0] stub_data;
    int          stub_lat;
    logic        stub_mute;
    logic        stub_spur;

    exp_request_arbiter #(.NUM_REQ(N), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_clamped(rsp_clamped), .rsp_timeout(rsp_timeout),
        .eu_x_in(eu_x_in), .eu_x_in_valid(eu_x_in_valid), .eu_x_in_ready(eu_x_in_ready),
        .eu_exp_out(eu_exp_out), .eu_output_valid(eu_output_valid),
        .eu_output_ready(eu_output_ready), .grant_id(grant_id), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign eu_output_valid = (stub_pend && stub_cnt == 0 && !stub_mute) || stub_spur;
    assign eu_exp_out      = stub_data;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            stub_pend <= 1'b0;
            stub_cnt  <= 0;
            stub_data <= '0;
        end else if (eu_x_in_valid && eu_x_in_ready) begin
            stub_pend <= 1'b1;
            stub_cnt  <= stub_lat;
            stub_data <= ~eu_x_in;
        end else if (stub_pend) begin
            if (eu_output_valid && eu_output_ready) stub_pend <= 1'b0;
            else if (stub_cnt > 0) stub_cnt <= stub_cnt - 1;
        end
    end

    function automatic logic [3:0] oh(input int i);
        return 4'b0001 << i;
    endfunction

    // Round-robin rule: first asserted requester after the last grant, wrapping.
    function automatic int winner(input logic [3:0] m);
        for (int k = 1; k <= N; k++)
            if (m[(last_grant + k) % N]) return (last_grant + k) % N;
        return 0;
    endfunction

    function automatic logic [64:0] sat(input logic [63:0] v);
        if ($signed(v) > 64'sd0) return {1'b1, 64'd0};
        if ($signed(v) < $signed(NEG1)) return {1'b1, NEG1};
        return {1'b0, v};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && rsp_valid !== '0) begin
            checks++;
            assert (rsp_valid === oh(mdl_grant)) else begin
                errors++;
                $error("FAIL mon_rsp_onehot observed=%b expected=%b", rsp_valid, oh(mdl_grant));
            end
        end
    end

    // Starts at #1 after an edge with the DUT idle; ends the same way.
    task automatic do_txn(input logic [3:0] vmask, input int lat, input bit mute,
                          input int xdelay, input int rdelay, input bit keep);
        int w, acc, n, explat;
        logic [63:0] op, xs, er;
        logic cl;
        stub_lat = lat;
        stub_mute = mute;
        eu_x_in_ready = (xdelay == 0);
        req_valid = vmask;
        #1;
        w = winner(vmask);
        chk("req_ready", 64'(req_ready), 64'(oh(w)));
        op = req_data[64*w +: 64];
        {cl, xs} = sat(op);
        er = mute ? 64'd0 : ~xs;
        mdl_grant = w;
        acc = cyc;
        @(posedge clk); #1;
        if (!keep) req_valid = '0;
        chk("grant_id", 64'(grant_id), 64'(w));
        chk("eu_x_in", eu_x_in, xs);
        chk("issue_state", 64'({eu_x_in_valid, busy, eu_output_ready}), 64'b110);
        for (int i = 0; i < xdelay; i++) begin
            chk("x_stall_data", eu_x_in, xs);
            chk("x_stall_valid", 64'(eu_x_in_valid), 64'd1);
            @(posedge clk); #1;
        end
        eu_x_in_ready = 1'b1;
        n = 0;
        while (rsp_valid === '0 && n < 600) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rsp_arrived", 64'(n < 600), 64'd1);
        explat = mute ? (2 + TIMEOUT + xdelay) : (3 + lat + xdelay);
        chk("latency", 64'(cyc - acc), 64'(explat));
        chk("rsp_valid", 64'(rsp_valid), 64'(oh(w)));
        chk("rsp_data", rsp_data, er);
        chk("rsp_flags", 64'({rsp_clamped, rsp_timeout}), 64'({cl, mute}));
        rsp_ready = ~oh(w);
        stub_spur = (rdelay > 0);
        for (int i = 0; i < rdelay; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 64'(rsp_valid), 64'(oh(w)));
            chk("hold_data", rsp_data, er);
        end
        stub_spur = 1'b0;
        rsp_ready = oh(w);
        @(posedge clk); #1;
        rsp_ready = '0;
        chk("done_idle", 64'({busy, rsp_valid}), 64'd0);
        last_grant = w;
        last_exp = er;
    endtask

    function automatic logic [63:0] rnd_op();
        logic [63:0] v;
        v = {$urandom, $urandom};
        case ($urandom_range(0, 2))
            0: return v;
            1: return {24'hFFFFFF, v[39:0]};
            default: return {24'hFFFFFF, 1'b1, v[38:0]};
        endcase
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req_valid = '1;
        req_data = '0;
        rsp_ready = '0;
        eu_x_in_ready = 1'b1;
        stub_lat = 0;
        stub_mute = 1'b0;
        stub_spur = 1'b0;
        last_grant = N - 1;
        mdl_grant = 0;
        last_exp = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_ctrl", 64'({rsp_valid, rsp_clamped, rsp_timeout, eu_x_in_valid,
                             eu_output_ready, grant_id, busy}), 64'd0);
        chk("rst_rsp_data", rsp_data, 64'd0);
        chk("rst_eu_x_in", eu_x_in, 64'd0);
        rst = 1'b0;
        req_valid = '0;

        // single request, latency 5
        req_data[63:0] = 64'hFFFFFF8000000000;
        do_txn(4'b0001, 5, 1'b0, 0, 0, 1'b0);
        chk("single_lit", rsp_data, 64'h0000007FFFFFFFFF);

        // saturation on both ends
        req_data[127:64] = 64'h0000000000000010;
        do_txn(4'b0010, 2, 1'b0, 0, 0, 1'b0);
        chk("clamp_pos", {eu_x_in[63:1], rsp_clamped}, 64'd1);
        req_data[191:128] = 64'h8000000000000000;
        do_txn(4'b0100, 1, 1'b0, 0, 0, 1'b0);
        chk("clamp_neg_x", eu_x_in, NEG1);
        chk("clamp_neg_flag", 64'(rsp_clamped), 64'd1);

        // exp unit never answers
        req_data[255:192] = 64'hFFFFFFC000000000;
        do_txn(4'b1000, 0, 1'b1, 0, 0, 1'b0);
        chk("timeout_out", {rsp_data[63:1], rsp_timeout}, 64'd1);

        // back-pressure on both handshakes, foreign rsp_ready bits and spurious eu valid
        req_data[63:0] = 64'hFFFFFFF123456789;
        do_txn(4'b0001, 2, 1'b0, 6, 20, 1'b0);

        // reset while waiting on the exp unit
        req_data[63:0] = 64'hFFFFFFA000000000;
        stub_mute = 1'b1;
        req_valid = 4'b0001;
        mdl_grant = winner(4'b0001);
        @(posedge clk); #1;
        req_valid = '0;
        repeat (4) @(posedge clk);
        #1;
        chk("in_wait", 64'({eu_output_ready, busy}), 64'b11);
        rst = 1'b1;
        req_valid = '1;
        #1;
        chk("midrst_ctrl", 64'({req_ready, rsp_valid, rsp_clamped, rsp_timeout, eu_x_in_valid,
                                eu_output_ready, grant_id, busy}), 64'd0);
        chk("midrst_data", rsp_data | eu_x_in, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = '0;
        stub_mute = 1'b0;
        last_grant = N - 1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("post_rst_quiet", 64'({busy, rsp_valid}), 64'd0);
        end

        // all requesters held valid: strict rotation from reset
        for (int k = 0; k < N; k++) req_data[64*k +: 64] = rnd_op();
        for (int i = 0; i < 8; i++) begin
            do_txn(4'b1111, i % 3, 1'b0, 0, 0, 1'b1);
            chk("rr_order", 64'(grant_id), 64'(i % N));
        end
        req_valid = '0;

        // randomized traffic
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < N; k++) req_data[64*k +: 64] = rnd_op();
            do_txn(4'($urandom_range(1, 15)), $urandom_range(0, 7), 1'b0,
                   $urandom_range(0, 2), $urandom_range(0, 3), 1'b0);
        end

        // eu_output_valid while idle must not start anything
        stub_spur = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("spur_idle", 64'({busy, eu_output_ready, rsp_valid}), 64'd0);
        end
        stub_spur = 1'b0;
        chk("spur_rsp_data", rsp_data, last_exp);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
